// File: rtl/mult_seq_ctrl_pkg.sv
// mult_pkg: shared width default and controller state encoding for the shift-and-add multiplier
package mult_pkg;
   localparam int DATA_WIDTH = 8;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      CLEAR  = 3'd3,
      ITER   = 3'd4,
      DONE   = 3'd5
   } state_e;
endpackage

// File: rtl/mult_seq_ctrl_iter_counter.sv
// iter_counter: add/shift iteration counter with sync clear, enable and terminal-count flag
// ports: i_clk/i_rst_n clock and sync active-low reset; i_clr zeroes the count; i_en
//        advances it; o_tc is high while the count equals DATA_WIDTH-1
module iter_counter #(
   parameter int DATA_WIDTH = mult_pkg::DATA_WIDTH
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);
   localparam int CNT_W = $clog2(DATA_WIDTH + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = i_clr ? '0 : i_en ? cnt_q + 1'b1 : cnt_q;
   always_ff @(posedge i_clk)
      if (!i_rst_n) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign o_tc = cnt_q == CNT_W'(DATA_WIDTH - 1);
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencing controller for the shift-and-add multiplier datapath
// ports: i_start/i_abort control, i_data_valid/o_data_ready operand handshake on data_in,
//        A_out is the datapath A-register LSB; load_A, load_B, clr_ACC_reg, load_ACC,
//        sel_SUM, shift_A_reg drive the datapath; o_busy outside IDLE, o_done one-cycle pulse
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int DATA_WIDTH = mult_pkg::DATA_WIDTH
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_start,
   input  logic i_abort,
   input  logic i_data_valid,
   output logic o_data_ready,
   input  logic A_out,
   output logic load_A,
   output logic load_B,
   output logic clr_ACC_reg,
   output logic load_ACC,
   output logic sel_SUM,
   output logic shift_A_reg,
   output logic o_busy,
   output logic o_done
);
   state_e state_q, state_d;
   logic cnt_tc;
   always_comb begin
      state_d = state_q;
      if (i_abort && state_q != IDLE) state_d = IDLE;
      else
         case (state_q)
            IDLE:    state_d = i_start ? LOAD_A : IDLE;
            LOAD_A:  state_d = i_data_valid ? LOAD_B : LOAD_A;
            LOAD_B:  state_d = i_data_valid ? CLEAR : LOAD_B;
            CLEAR:   state_d = ITER;
            ITER:    state_d = cnt_tc ? DONE : ITER;
            default: state_d = IDLE;
         endcase
   end
   always_ff @(posedge i_clk)
      if (!i_rst_n) state_q <= IDLE;
      else state_q <= state_d;
   iter_counter #(.DATA_WIDTH(DATA_WIDTH)) u_cnt (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (state_q == CLEAR),
      .i_en    (state_q == ITER),
      .o_tc    (cnt_tc)
   );
   assign o_data_ready = state_q == LOAD_A || state_q == LOAD_B;
   assign load_A       = state_q == LOAD_A && i_data_valid;
   assign load_B       = state_q == LOAD_B && i_data_valid;
   assign clr_ACC_reg  = state_q == CLEAR;
   assign load_ACC     = state_q == ITER;
   assign shift_A_reg  = state_q == ITER;
   // only Mealy term: add B when the multiplier bit currently at A[0] is set
   assign sel_SUM      = state_q == ITER && A_out;
   assign o_busy       = state_q != IDLE;
   assign o_done       = state_q == DONE;
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: scoreboard bench driving the controller against a behavioural datapath
module tb_mult_seq_ctrl;
   logic clk = 0, rst_n = 0, start = 0, abort = 0, valid = 0;
   logic [7:0] din = 0;
   logic o_data_ready, A_out, load_A, load_B, clr_ACC_reg, load_ACC, sel_SUM, shift_A_reg, o_busy, o_done;
   logic [8:0] outs;
   logic [7:0] a_reg = 0, b_reg = 0, acc_reg = 0;
   logic [8:0] mux;
   typedef struct {logic [15:0] prod; int dcyc; int ones;} exp_t;
   exp_t expq[$];
   exp_t e;
   int cyc = 0, checks = 0, failures = 0, done_cnt = 0, nacc = 0, nsel = 0;

   always #5 clk = ~clk;

   mult_seq_ctrl dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
      .i_data_valid(valid), .o_data_ready(o_data_ready), .A_out(A_out),
      .load_A(load_A), .load_B(load_B), .clr_ACC_reg(clr_ACC_reg), .load_ACC(load_ACC),
      .sel_SUM(sel_SUM), .shift_A_reg(shift_A_reg), .o_busy(o_busy), .o_done(o_done)
   );

   assign outs = {o_data_ready, load_A, load_B, clr_ACC_reg, load_ACC, sel_SUM, shift_A_reg, o_busy, o_done};
   assign A_out = a_reg[0];
   assign mux = sel_SUM ? {1'b0, acc_reg} + {1'b0, b_reg} : {1'b0, acc_reg};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (load_A) a_reg <= din;
      else if (shift_A_reg) a_reg <= {mux[0], a_reg[7:1]};
      if (load_B) b_reg <= din;
      if (clr_ACC_reg) acc_reg <= 0;
      else if (load_ACC) acc_reg <= mux[8:1];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (load_A || load_B) chk("load_needs_valid", {31'd0, valid}, 1);
      if (clr_ACC_reg) begin
         nacc = 0;
         nsel = 0;
      end
      if (load_ACC) begin
         nacc++;
         if (sel_SUM) nsel++;
      end
      if (o_done) begin
         done_cnt++;
         if (expq.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = expq.pop_front();
            chk("product", {16'd0, acc_reg, a_reg}, {16'd0, e.prod});
            chk("done_cycle", cyc, e.dcyc);
            chk("load_acc_pulses", nacc, 8);
            chk("sel_sum_pulses", nsel, e.ones);
         end
      end
   end

   // mode 0 plain, 1 abort in 4th ITER cycle, 2 reset in LOAD_B, 3 start pulses while busy and in DONE
   task automatic run(input logic [7:0] a, input logic [7:0] b, input int sa, input int sb, input int mode);
      int ts, dc, base;
      base = done_cnt;
      @(posedge clk); #1;
      start = 1;
      ts = cyc;
      dc = ts + 12 + sa + sb;
      expq.push_back('{prod: 16'(a) * 16'(b), dcyc: dc, ones: $countones(a)});
      @(posedge clk); #1;
      start = 0;
      repeat (sa) begin @(posedge clk); #1; end
      valid = 1; din = a;
      @(posedge clk); #1;
      valid = 0; din = 8'($urandom);
      if (mode == 2) begin
         rst_n = 0;
         @(posedge clk); #1;
         chk("reset_mid_outputs", {23'd0, outs}, 0);
         void'(expq.pop_back());
         rst_n = 1;
         repeat (3) begin @(posedge clk); #1; end
         chk("no_done_after_reset", done_cnt, base);
         return;
      end
      repeat (sb) begin @(posedge clk); #1; end
      valid = 1; din = b;
      @(posedge clk); #1;
      valid = 0; din = 8'($urandom);
      if (mode == 1) begin
         repeat (4) begin @(posedge clk); #1; end
         abort = 1;
         @(posedge clk); #1;
         abort = 0;
         chk("abort_busy", {31'd0, o_busy}, 0);
         void'(expq.pop_back());
         repeat (14) begin @(posedge clk); #1; end
         chk("no_done_after_abort", done_cnt, base);
         return;
      end
      if (mode == 3) begin
         repeat (3) begin
            @(posedge clk); #1; start = 1;
            @(posedge clk); #1; start = 0;
         end
         while (cyc < dc) begin @(posedge clk); #1; end
         start = 1;
         @(posedge clk); #1;
         start = 0;
         repeat (3) begin
            chk("idle_after_done", {30'd0, o_busy, o_data_ready}, 0);
            @(posedge clk); #1;
         end
      end else begin
         for (int i = 0; i < 40 && done_cnt == base; i++) begin @(posedge clk); #1; end
      end
      chk("one_done", done_cnt, base + 1);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {23'd0, outs}, 0);
      @(posedge clk); #1;
      rst_n = 1;
      run(8'd13, 8'd11, 0, 0, 0);
      run(8'd255, 8'd255, 0, 0, 0);
      run(8'd0, 8'hA5, 0, 0, 0);
      run(8'd7, 8'd9, 3, 2, 0);
      run(8'd100, 8'd200, 0, 0, 1);
      run(8'd3, 8'd5, 0, 0, 0);
      run(8'd42, 8'd17, 1, 0, 2);
      run(8'd6, 8'd7, 0, 0, 3);
      for (int i = 0; i < 25; i++)
         run(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
      repeat (3) @(posedge clk);
      chk("queue_drained", expq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequencing controller for the 8-bit shift-and-add multiplier datapath. It accepts a start request, loads the multiplicand and multiplier over the shared `data_in` bus using a valid/ready handshake, and clears the accumulator. It then runs DATA_WIDTH add/shift iterations and signals completion. It drives every datapath control strobe and samples only the datapath's A-register LSB; the 2×DATA_WIDTH product is read from {out_ACC_reg, out_A_reg}.

## Interface
- DATA_WIDTH, 8, operand width; sets the iteration count.
- CNT_W, $clog2(DATA_WIDTH+1), iteration counter width (derived, not overridden).

- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_start  in  1  start request; accepted only in IDLE.
- i_abort  in  1  synchronous abort; returns to IDLE from any non-IDLE state.
- i_data_valid  in  1  data_in carries a valid operand this cycle.
- o_data_ready  out  1  controller will consume data_in this cycle (LOAD_A or LOAD_B).
- A_out  in  1  LSB of A register from datapath.
- load_A  out  1  load A register (multiplier) from data_in.
- load_B  out  1  load B register (multiplicand) from data_in.
- clr_ACC_reg  out  1  clear accumulator.
- load_ACC  out  1  accumulator captures shifted mux result.
- sel_SUM  out  1  mux selects SUM (1) or ACC (0).
- shift_A_reg  out  1  shift A right, MSB fed from shift_ADD[0].
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse; product valid on datapath outputs.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CLEAR, ITER, DONE.
- IDLE: if i_start, go to LOAD_A. Otherwise remain in IDLE.
- LOAD_A: o_data_ready=1; load_A = i_data_valid. On valid, go to LOAD_B. Otherwise stall.
- LOAD_B: o_data_ready=1; load_B = i_data_valid. On valid, go to CLEAR. Otherwise stall.
- CLEAR: clr_ACC_reg=1; counter ← 0; go to ITER.
- ITER: load_ACC=1, shift_A_reg=1, sel_SUM=A_out (combinational Mealy term, ITER only). Counter increments each cycle. When counter == DATA_WIDTH-1, go to DONE.
- DONE: o_done=1 for exactly one cycle; go to IDLE. The datapath holds the product until the next load.
- All strobes other than sel_SUM are decoded from the state register. Every strobe is 0 outside the state listed above.
- i_abort has priority over all transitions except reset. Any state except IDLE goes to IDLE next cycle with no o_done. Strobes in the abort cycle still follow the current state. Datapath registers are left as-is.
- i_start while o_busy=1 is ignored; it is not queued.
- i_start in the same cycle as DONE is ignored. A new start is accepted from IDLE at the earliest one cycle later.

## Timing
- Reset (i_rst_n=0 at an edge) puts the state in IDLE, the counter at 0, and all outputs at 0 the following cycle. Reset mid-operation has the same effect, and no o_done is produced.
- Latency with no valid stalls, start sampled at edge t:
  - LOAD_A is t+1, LOAD_B is t+2, CLEAR is t+3.
  - ITER runs t+4 … t+3+DATA_WIDTH.
  - o_done is at t+4+DATA_WIDTH (t+12 for width 8).
- Each stalled cycle in LOAD_A or LOAD_B adds exactly one cycle.
- Handshake: an operand is transferred on a cycle with i_data_valid & o_data_ready. A is transferred first, then B. Back-to-back valid is consumed on consecutive cycles.
- Exactly DATA_WIDTH load_ACC/shift_A_reg pulses occur per multiplication, never more or fewer.

## Structure
- Shared package `mult_pkg`:
  - DATA_WIDTH default.
  - State enum, encoded {IDLE=0, LOAD_A, LOAD_B, CLEAR, ITER, DONE}.
- The iteration counter is a natural sub-module: `iter_counter`, with sync clear, enable, and a terminal-count flag at DATA_WIDTH-1.
- Top-level integration instantiates mult_seq_ctrl alongside the datapath, with A_out wired back to this controller.

## Test plan
- Reset, then start; data_in = 13 then 11 with valid held high → o_done at start+12; ACC=0x00, A=0x8F (143); 8 load_ACC pulses observed.
- 255 × 255 → {ACC, A} = 0xFE01. 0 × 0xA5 → 0x0000, and sel_SUM never asserted.
- Valid deasserted for 3 cycles in LOAD_A and 2 in LOAD_B, for 7 × 9 → o_done at start+17; product 0x003F; no load_A/load_B while valid=0.
- i_abort in the 4th ITER cycle → IDLE next cycle; no o_done; o_busy=0. A subsequent 3 × 5 → 0x000F.
- i_rst_n low in LOAD_B, then released → all outputs 0; i_start pulses during busy and in the DONE cycle are ignored (no extra LOAD_A entry).
